mmio_responder: RTL
===================

# mmio_responder

Memory-side responder for the multi-cycle CPU's load/store path. Accepts one request at a time from the core's bus interface and decodes the address into either the external synchronous block RAM or a small bank of game I/O registers. The I/O registers are the LED output, the synchronized switch input, the countdown timer and the strike counter. It returns read data with a valid pulse, so the control FSM can stall writeback until data arrives.

## Interface
Parameters:
- RAM_DEPTH, 16384: number of 16-bit RAM words; RAM region is addresses 0 .. RAM_DEPTH-1.
- IO_BASE, 16'hFF00: base of the I/O register window (4 registers).
- TICK_DIV, 50000000: clock cycles per timer decrement.

Ports:
- clock, in, 1: system clock, all logic on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- reqValid, in, 1: request present.
- reqReady, out, 1: responder can accept; a request is accepted on a cycle with reqValid && reqReady.
- reqWe, in, 1: 1 = store, 0 = load.
- reqAddr, in, 16: word address.
- reqWData, in, 16: store data.
- respValid, out, 1: one-cycle pulse; read data or write completion.
- respRData, out, 16: load data, valid while respValid=1, 0 otherwise.
- ramAddr, out, 16: RAM address.
- ramWe, out, 1: RAM write strobe.
- ramWData, out, 16: RAM write data.
- ramRData, in, 16: RAM read data, 1-cycle latency after address.
- switches, in, 10: asynchronous board switches.
- leds, out, 10: LED register.
- timeUp, out, 1: high while the timer value is 0.
- strikes, out, 2: strike count.
- errFlag, out, 1: sticky; set by any access to an unmapped address.

## Operation
- States: IDLE, RAM_WAIT, RESP. reqReady = (state == IDLE).
- IDLE, accept, RAM address, store:
  - ramWe=1 and ramAddr/ramWData driven combinationally in the accept cycle.
  - Go to RESP.
- IDLE, accept, RAM address, load:
  - ramAddr driven in the accept cycle.
  - Go to RAM_WAIT, capturing ramRData into the response register on the next edge.
  - Then go to RESP.
- IDLE, accept, I/O or unmapped: perform the register access on the accept edge, go to RESP.
- RESP: respValid=1 for exactly one cycle, return to IDLE.
- I/O map, relative to IO_BASE:
  - +0 leds: R/W, write takes reqWData[9:0].
  - +1 switches: R only, two-flop synchronized, zero-extended.
  - +2 timer: R/W, 16-bit; a write loads the value and clears the prescaler.
  - +3 strikes: a write of any value increments the count, saturating at 3; a read returns the zero-extended count.
- Unmapped means address >= RAM_DEPTH and outside IO_BASE..IO_BASE+3:
  - Loads return 0.
  - Stores are ignored.
  - errFlag sets.
- A write to switches is ignored without an error.
- Timer:
  - The prescaler counts 0..TICK_DIV-1.
  - At wrap, the timer decrements if nonzero, saturating at 0.
  - The timer runs independent of bus activity.
- Reset values:
  - State IDLE, so reqReady=1.
  - respValid=0, respRData=0, ramWe=0, ramAddr=0, ramWData=0.
  - leds=0, timer=0 (timeUp=1), prescaler=0, strikes=0, errFlag=0, synchronizer flops=0.

## Timing
- Latency from the accept edge to the respValid cycle:
  - RAM load: 2 cycles.
  - RAM store, I/O access, unmapped access: 1 cycle.
- Throughput: at most one request per 2 cycles (RAM store/I/O) or 3 cycles (RAM load).
- reqValid while not ready is held off. Request fields must stay stable until accepted; they are not needed after acceptance.
- A timer write in the same cycle as a prescaler wrap: the write wins and the prescaler restarts at 0.
- Strike increment at 3: stays 3, no error.
- A timer read returns the value before any same-edge decrement.
- An asynchronous reset mid-transaction aborts it:
  - No respValid is issued.
  - ramWe drops immediately.
  - The requester must reissue.

## Structure
- Shared package:
  - Register offsets LEDS_OFS=0, SW_OFS=1, TIMER_OFS=2, STRIKE_OFS=3.
  - The 2-bit state encoding: IDLE=0, RAM_WAIT=1, RESP=2.
- One natural sub-module: countdown_timer (prescaler + saturating 16-bit down counter, with load port and timeUp output).
- Everything else stays inline.

## Test plan
- Reset, then store 16'hBEEF to address 16'h0010:
  - ramWe=1 with ramAddr=16'h0010 in the accept cycle.
  - respValid one cycle later.
- Load 16'h0010 with the RAM model returning 16'hBEEF:
  - respValid exactly 2 cycles after accept, with respRData=16'hBEEF.
  - reqReady=0 during those 2 cycles.
- Store 16'h03FF to IO_BASE+0, then load IO_BASE+1 with switches=10'h155 held for 3+ cycles:
  - leds=10'h3FF.
  - Read returns 16'h0155.
- With TICK_DIV=4, store 3 to IO_BASE+2:
  - The timer reads 3, 2, 1, 0 at 4-cycle spacing.
  - timeUp rises at 0 and the timer stays 0.
  - A store coinciding with a wrap loads cleanly.
- Four stores to IO_BASE+3:
  - strikes = 1, 2, 3, 3.
- Load 16'h8000 with RAM_DEPTH=16384:
  - respRData=0 and errFlag=1, sticky until reset.
  - Assert reset mid-RAM_WAIT: no respValid, reqReady=1.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: I/O register offsets and the
// bus FSM state encoding.
package mmio_responder_pkg;

   localparam logic [1:0] LEDS_OFS   = 2'd0;
   localparam logic [1:0] SW_OFS     = 2'd1;
   localparam logic [1:0] TIMER_OFS  = 2'd2;
   localparam logic [1:0] STRIKE_OFS = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      RESP     = 2'd2
   } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Prescaled saturating 16-bit down counter; a load restarts the prescaler.
module countdown_timer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] loadVal,
   output logic [15:0] value,
   output logic        timeUp
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;

   // A load on a wrap edge wins: the decrement is dropped and the prescaler restarts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         value <= '0;
      end else if (load) begin
         presc <= '0;
         value <= loadVal;
      end else if (presc == LAST) begin
         presc <= '0;
         if (value != 16'd0) value <= value - 16'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign timeUp = (value == 16'd0);

endmodule

// File: rtl/mmio_responder.sv
// Single-outstanding load/store responder: decodes into block RAM or the
// game I/O registers and returns a one-cycle response pulse.
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter int          RAM_DEPTH = 16384,
   parameter logic [15:0] IO_BASE   = 16'hFF00,
   parameter int          TICK_DIV  = 50000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWe,
   input  logic [15:0] reqAddr,
   input  logic [15:0] reqWData,
   output logic        respValid,
   output logic [15:0] respRData,
   output logic [15:0] ramAddr,
   output logic        ramWe,
   output logic [15:0] ramWData,
   input  logic [15:0] ramRData,
   input  logic [9:0]  switches,
   output logic [9:0]  leds,
   output logic        timeUp,
   output logic [1:0]  strikes,
   output logic        errFlag
);

   localparam logic [16:0] RAM_LIM = 17'(RAM_DEPTH);

   state_t      state, nxt;
   logic        accept, isIo, isRam;
   logic [15:0] ioOfs, ioRd, respReg, timerVal;
   logic [9:0]  sw1, swSync;
   logic        timerLoad;

   assign ioOfs = reqAddr - IO_BASE;
   assign isIo  = (ioOfs < 16'd4);
   assign isRam = !isIo && ({1'b0, reqAddr} < RAM_LIM);
   // Gating with reset keeps the RAM strobe quiet while reset is held.
   assign accept    = reqValid && (state == IDLE) && reset;
   assign timerLoad = accept && isIo && reqWe && (ioOfs[1:0] == TIMER_OFS);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (accept) nxt = (isRam && !reqWe) ? RAM_WAIT : RESP;
         RAM_WAIT: nxt = RESP;
         RESP:     nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_comb begin
      reqReady  = (state == IDLE);
      respValid = (state == RESP);
      respRData = (state == RESP) ? respReg : 16'd0;
      ramWe     = accept && isRam && reqWe;
      ramAddr   = (accept && isRam) ? reqAddr : 16'd0;
      ramWData  = (accept && isRam && reqWe) ? reqWData : 16'd0;
   end

   always_comb begin
      case (ioOfs[1:0])
         LEDS_OFS:  ioRd = {6'd0, leds};
         SW_OFS:    ioRd = {6'd0, swSync};
         TIMER_OFS: ioRd = timerVal;
         default:   ioRd = {14'd0, strikes};
      endcase
   end

   // RAM loads overwrite the accept-edge zero once the RAM data arrives.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 respReg <= '0;
      else if (accept)            respReg <= (isIo && !reqWe) ? ioRd : 16'd0;
      else if (state == RAM_WAIT) respReg <= ramRData;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         leds    <= '0;
         strikes <= '0;
         errFlag <= 1'b0;
         sw1     <= '0;
         swSync  <= '0;
      end else begin
         sw1    <= switches;
         swSync <= sw1;
         if (accept && isIo && reqWe && (ioOfs[1:0] == LEDS_OFS)) leds <= reqWData[9:0];
         if (accept && isIo && reqWe && (ioOfs[1:0] == STRIKE_OFS) && (strikes != 2'd3))
            strikes <= strikes + 2'd1;
         if (accept && !isIo && !isRam) errFlag <= 1'b1;
      end
   end

   countdown_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (timerLoad),
      .loadVal (reqWData),
      .value   (timerVal),
      .timeUp  (timeUp)
   );

endmodule
